// File: rtl/binary_down_counter.sv
// -----------------------------------------------------------------------------
// binary_down_counter
//
// Purpose:
//   8-bit loadable down counter with a three-state control FSM (IDLE/RUN/DONE),
//   an internal reload register for optional auto-reload, and a registered
//   one-cycle terminal-count pulse. All state is synchronous to i_clk, and the
//   active-low reset is sampled on the rising edge only.
//
// Ports:
//   i_clk      system clock, rising-edge active
//   i_rst_n    synchronous active-low reset
//   i_t        count enable (one decrement per edge while in RUN)
//   i_load     load strobe; i_d becomes both count and reload value
//   i_d[7:0]   load value
//   i_reload   auto-reload select, only looked at on the terminal decrement
//   i_ack      acknowledge of DONE; returns the block to IDLE
//   o_counter  current count (register)
//   o_tc       registered terminal-count pulse, one cycle wide
//   o_zero     high when the count register is zero
//   o_busy     high in RUN
//   o_done     high in DONE
// -----------------------------------------------------------------------------
module binary_down_counter (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_t,
  input  logic       i_load,
  input  logic [7:0] i_d,
  input  logic       i_reload,
  input  logic       i_ack,
  output logic [7:0] o_counter,
  output logic       o_tc,
  output logic       o_zero,
  output logic       o_busy,
  output logic       o_done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t     r_state;
  logic [7:0] r_counter;
  logic [7:0] r_reload;
  logic       r_tc;

  state_t     w_state_nxt;
  logic [7:0] w_counter_nxt;
  logic [7:0] w_reload_nxt;
  logic       w_tc_nxt;

  // Next-state and next-datapath decode; LOAD overrides everything else.
  always_comb begin
    w_state_nxt   = r_state;
    w_counter_nxt = r_counter;
    w_reload_nxt  = r_reload;
    w_tc_nxt      = 1'b0;

    if (i_load) begin
      w_counter_nxt = i_d;
      w_reload_nxt  = i_d;
      // A zero load has nothing to count, so it parks in IDLE.
      w_state_nxt   = (i_d != 8'd0) ? ST_RUN : ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_IDLE;
        end
        ST_RUN: begin
          if (i_t) begin
            if (r_counter > 8'd1) begin
              w_counter_nxt = r_counter - 8'd1;
            end else if (r_counter == 8'd1) begin
              // Terminal decrement: RELOAD is only sampled here.
              w_tc_nxt = 1'b1;
              if (i_reload) begin
                w_counter_nxt = r_reload;
                w_state_nxt   = ST_RUN;
              end else begin
                w_counter_nxt = 8'd0;
                w_state_nxt   = ST_DONE;
              end
            end else begin
              // Zero count in RUN is unreachable; never wrap, fall back to IDLE.
              w_counter_nxt = 8'd0;
              w_state_nxt   = ST_IDLE;
            end
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_DONE: begin
          if (i_ack) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end
        default: begin
          // Illegal encoding recovers to IDLE on the next edge.
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // State, count, reload and TC registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_counter <= 8'd0;
      r_reload  <= 8'd0;
      r_tc      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_counter <= w_counter_nxt;
      r_reload  <= w_reload_nxt;
      r_tc      <= w_tc_nxt;
    end
  end

  assign o_counter = r_counter;
  assign o_tc      = r_tc;
  assign o_zero    = (r_counter == 8'd0);
  assign o_busy    = (r_state == ST_RUN);
  assign o_done    = (r_state == ST_DONE);

endmodule

// File: tb/tb_binary_down_counter.sv
// -----------------------------------------------------------------------------
// tb_binary_down_counter
//
// Directed self-checking bench for binary_down_counter. Inputs change 1 time
// unit after a rising edge; outputs are checked at that same point, so each
// check sees the result of the edge just taken.
// -----------------------------------------------------------------------------
module tb_binary_down_counter;

  logic       clk;
  logic       rst_n;
  logic       t;
  logic       load;
  logic [7:0] d;
  logic       reload;
  logic       ack;
  logic [7:0] counter;
  logic       tc;
  logic       zero;
  logic       busy;
  logic       done;

  int vectors;
  int errors;

  binary_down_counter dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_t       (t),
    .i_load    (load),
    .i_d       (d),
    .i_reload  (reload),
    .i_ack     (ack),
    .o_counter (counter),
    .o_tc      (tc),
    .o_zero    (zero),
    .o_busy    (busy),
    .o_done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] exp_cnt;
    logic       exp_tc;
    int         tc_count;
    int         ff_seen;

    vectors = 0;
    errors  = 0;
    rst_n = 1'b0; t = 1'b0; load = 1'b0; d = 8'd0; reload = 1'b0; ack = 1'b0;

    // Reset: two cycles low, with LOAD/T/ACK also high to show reset wins.
    tick();
    load = 1'b1; d = 8'h33; t = 1'b1; ack = 1'b1;
    tick();
    chk("rst_counter", 32'(counter), 32'h00);
    chk("rst_tc",      32'(tc),      32'd0);
    chk("rst_zero",    32'(zero),    32'd1);
    chk("rst_busy",    32'(busy),    32'd0);
    chk("rst_done",    32'(done),    32'd0);
    load = 1'b0; t = 1'b0; ack = 1'b0;
    rst_n = 1'b1;

    // One-shot: load 3, count 3,2,1,0 with TC on the step to 0.
    load = 1'b1; d = 8'h03;
    tick();
    chk("os_load_cnt",  32'(counter), 32'h03);
    chk("os_load_busy", 32'(busy),    32'd1);
    load = 1'b0; t = 1'b1;
    tick();
    chk("os_cnt2", 32'(counter), 32'h02);
    chk("os_tc2",  32'(tc),      32'd0);
    tick();
    chk("os_cnt1", 32'(counter), 32'h01);
    chk("os_tc1",  32'(tc),      32'd0);
    tick();
    chk("os_cnt0",  32'(counter), 32'h00);
    chk("os_tc0",   32'(tc),      32'd1);
    chk("os_done",  32'(done),    32'd1);
    chk("os_busy",  32'(busy),    32'd0);
    tick();
    chk("os_hold_cnt", 32'(counter), 32'h00);
    chk("os_hold_tc",  32'(tc),      32'd0);
    chk("os_hold_done", 32'(done),   32'd1);
    t = 1'b0; ack = 1'b1;
    tick();
    chk("os_ack_done", 32'(done), 32'd0);
    chk("os_ack_busy", 32'(busy), 32'd0);
    chk("os_ack_zero", 32'(zero), 32'd1);
    ack = 1'b0;

    // Auto-reload with period 4 over 12 enabled cycles.
    load = 1'b1; d = 8'h04; reload = 1'b1;
    tick();
    chk("ar_load_cnt", 32'(counter), 32'h04);
    load = 1'b0; t = 1'b1;
    exp_cnt  = 8'h04;
    tc_count = 0;
    for (int i = 0; i < 12; i++) begin
      exp_tc  = (exp_cnt == 8'h01);
      exp_cnt = (exp_cnt == 8'h01) ? 8'h04 : exp_cnt - 8'h01;
      tick();
      chk("ar_cnt",  32'(counter), 32'(exp_cnt));
      chk("ar_tc",   32'(tc),      32'(exp_tc));
      chk("ar_busy", 32'(busy),    32'd1);
      if (tc) tc_count++;
    end
    chk("ar_tc_pulses", 32'(tc_count), 32'd3);

    // Auto-reload with reload value 1: TC every cycle, count stays 1.
    t = 1'b0; load = 1'b1; d = 8'h01;
    tick();
    load = 1'b0; t = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ar1_cnt", 32'(counter), 32'h01);
      chk("ar1_tc",  32'(tc),      32'd1);
    end

    // Gated count: T toggles 1,0,1,0 -> 5,4,4,3,3, no TC.
    t = 1'b0; reload = 1'b0; load = 1'b1; d = 8'h05;
    tick();
    chk("g_load_cnt", 32'(counter), 32'h05);
    load = 1'b0;
    t = 1'b1; tick(); chk("g_cnt_a", 32'(counter), 32'h04); chk("g_tc_a", 32'(tc), 32'd0);
    t = 1'b0; reload = 1'b1;
    tick(); chk("g_cnt_b", 32'(counter), 32'h04); chk("g_tc_b", 32'(tc), 32'd0);
    t = 1'b1; reload = 1'b0;
    tick(); chk("g_cnt_c", 32'(counter), 32'h03); chk("g_tc_c", 32'(tc), 32'd0);
    t = 1'b0; tick(); chk("g_cnt_d", 32'(counter), 32'h03); chk("g_tc_d", 32'(tc), 32'd0);

    // Run out to DONE, then LOAD+ACK together: LOAD wins.
    t = 1'b1;
    tick(); tick(); tick();
    chk("p_done_reached", 32'(done), 32'd1);
    t = 1'b0; load = 1'b1; ack = 1'b1; d = 8'h02;
    tick();
    chk("p_busy", 32'(busy),    32'd1);
    chk("p_done", 32'(done),    32'd0);
    chk("p_cnt",  32'(counter), 32'h02);
    ack = 1'b0; d = 8'h00;
    tick();
    chk("p_zero_busy", 32'(busy), 32'd0);
    chk("p_zero_zero", 32'(zero), 32'd1);
    chk("p_zero_done", 32'(done), 32'd0);
    load = 1'b0; t = 1'b1;
    tick();
    chk("p_idle_cnt",  32'(counter), 32'h00);
    chk("p_idle_busy", 32'(busy),    32'd0);
    chk("p_idle_tc",   32'(tc),      32'd0);

    // Reset mid-run: 0xFF down 10 steps to 0xF5, then reset.
    t = 1'b0; load = 1'b1; d = 8'hFF;
    tick();
    load = 1'b0; t = 1'b1;
    tc_count = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (tc) tc_count++;
    end
    chk("mr_cnt", 32'(counter), 32'hF5);
    rst_n = 1'b0;
    tick();
    if (tc) tc_count++;
    chk("mr_rst_cnt",  32'(counter), 32'h00);
    chk("mr_rst_busy", 32'(busy),    32'd0);
    chk("mr_rst_done", 32'(done),    32'd0);
    chk("mr_rst_zero", 32'(zero),    32'd1);
    rst_n = 1'b1;
    tick();
    if (tc) tc_count++;
    chk("mr_after_cnt", 32'(counter), 32'h00);
    chk("mr_tc_never",  32'(tc_count), 32'd0);

    // Full range: 0xFF down to 0 in 255 enabled cycles, one TC at the end.
    t = 1'b0; load = 1'b1; d = 8'hFF;
    tick();
    load = 1'b0; t = 1'b1;
    tc_count = 0;
    ff_seen  = 0;
    for (int i = 1; i <= 255; i++) begin
      tick();
      chk("fr_cnt", 32'(counter), 32'(255 - i));
      chk("fr_tc",  32'(tc),      (i == 255) ? 32'd1 : 32'd0);
      if (tc) tc_count++;
      if (counter == 8'hFF) ff_seen++;
    end
    chk("fr_tc_count", 32'(tc_count), 32'd1);
    chk("fr_no_ff",    32'(ff_seen),  32'd0);
    chk("fr_done",     32'(done),     32'd1);
    tick();
    chk("fr_tc_after",  32'(tc),      32'd0);
    chk("fr_cnt_after", 32'(counter), 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
